// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle trigger strobes into fixed-width output
// pulses of HIGH_CYCLES periods with a guaranteed GAP_CYCLES low time between
// them. Requests that arrive while a pulse or gap is in progress are queued
// (up to QDEPTH). Further requests are dropped and flagged on overflow.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QDEPTH      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    output logic       y,
    output logic       busy,
    output logic [1:0] pending,
    output logic       overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] HLOAD = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] GLOAD = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] QMAX  = 2'(QDEPTH);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] pend_q,  pend_d;
    logic       ovf_q,   ovf_d;

    logic last_gap;
    logic enq;
    logic deq;

    // The last GAP edge decides between the next pulse and IDLE.
    assign last_gap = (state_q == ST_GAP) && (cnt_q == '0);

    // A queued request is consumed when the gap completes.
    assign deq = last_gap && (pend_q != '0);

    // A trig on the last GAP edge with nothing queued starts the next pulse
    // directly, exactly as it would from IDLE; queueing it instead would leave
    // a request stranded in IDLE.
    assign enq = trig && (state_q != ST_IDLE) && !(last_gap && (pend_q == '0));

    // Next-state, counter and pending-queue logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_HIGH;
                    cnt_d   = HLOAD;
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GLOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if ((pend_q != '0) || trig) begin
                        state_d = ST_HIGH;
                        cnt_d   = HLOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Simultaneous enqueue and dequeue leaves the count unchanged.
        if (enq && !deq) begin
            if (pend_q == QMAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (deq && !enq) begin
            pend_d = pend_q - 2'd1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y        = (state_q == ST_HIGH);
    assign busy     = (state_q != ST_IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with a per-cycle reference model feeding
// a scoreboard of expected output values.
module tb_pulse_stretcher;

    localparam int H = 4;
    localparam int G = 2;
    localparam int Q = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       trig  = 1'b0;
    logic       y;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .QDEPTH     (Q)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .trig    (trig),
        .y       (y),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       y;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0=idle 1=high 2=gap, rem = cycles left in phase.
    int m_phase = 0;
    int m_rem   = 0;
    int m_q     = 0;
    bit m_ovf   = 0;

    int   rises       = 0;
    int   falls_after = 0;
    bit   released    = 0;
    logic last_y      = 1'b0;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_rem   = 0;
        m_q     = 0;
        m_ovf   = 0;
    endfunction

    function automatic void queue_req();
        if (m_q < Q) m_q++;
        else         m_ovf = 1;
    endfunction

    function automatic void model_step(input bit t, input bit r);
        if (r) begin
            model_reset();
            return;
        end
        m_ovf = 0;
        case (m_phase)
            0: begin
                if (t) begin
                    m_phase = 1;
                    m_rem   = H;
                end
            end
            1: begin
                if (t) queue_req();
                if (m_rem == 1) begin
                    m_phase = 2;
                    m_rem   = G;
                end else begin
                    m_rem--;
                end
            end
            default: begin
                if (m_rem == 1) begin
                    if (m_q > 0 || t) begin
                        m_phase = 1;
                        m_rem   = H;
                        if (m_q > 0 && !t) m_q--;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_rem--;
                    if (t) queue_req();
                end
            end
        endcase
    endfunction

    task automatic step(input bit t, input bit r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        trig  = t;
        reset = r;
        model_step(t, r);
        e.y    = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.pend = 2'(m_q);
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp("y",        {7'd0, y},        {7'd0, got.y});
        cmp("busy",     {7'd0, busy},     {7'd0, got.busy});
        cmp("pending",  {6'd0, pending},  {6'd0, got.pend});
        cmp("overflow", {7'd0, overflow}, {7'd0, got.ovf});
        if (y && !last_y) rises++;
        if (!y && last_y && released) falls_after++;
        last_y = y;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset is applied from time zero, before any clock edge.
        #1;
        cmp("rst_y",        {7'd0, y},        8'd0);
        cmp("rst_busy",     {7'd0, busy},     8'd0);
        cmp("rst_pending",  {6'd0, pending},  8'd0);
        cmp("rst_overflow", {7'd0, overflow}, 8'd0);
        model_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single request.
        step(1'b1, 1'b0);
        idle(8);

        // Two requests two edges apart.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(12);

        // Five back-to-back requests: queue fills, fifth is dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        idle(26);

        // Trig on the final gap edge with one request queued.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0);
        cmp("final_gap_pending",  {6'd0, pending},  8'd1);
        cmp("final_gap_overflow", {7'd0, overflow}, 8'd0);
        cmp("final_gap_y",        {7'd0, y},        8'd1);
        idle(20);

        // Asynchronous reset mid-HIGH with two requests queued.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        cmp("async_rst_y",       {7'd0, y},       8'd0);
        cmp("async_rst_busy",    {7'd0, busy},    8'd0);
        cmp("async_rst_pending", {6'd0, pending}, 8'd0);
        step(1'b0, 1'b1);
        rises = 0;
        step(1'b1, 1'b0);
        idle(10);
        cmp("post_reset_pulses", 8'(rises), 8'd1);

        // trig held high for 20 edges from IDLE.
        rises       = 0;
        falls_after = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        released = 1;
        idle(30);
        cmp("held_total_pulses",     8'(rises),       8'd7);
        cmp("held_pulses_after_rel", 8'(falls_after), 8'd4);
        cmp("held_end_busy",         {7'd0, busy},    8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 The block SHALL have parameter HIGH_CYCLES, default 4: output high time in clock periods; legal range 1..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: minimum output low time between pulses in clock periods; legal range 1..255.
REQ-003 The block SHALL have parameter QDEPTH, default 3: maximum queued requests; legal range 1..3.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port trig, input, 1 bit: request strobe; each rising clk edge with trig=1 counts as one request.
REQ-007 The block SHALL have port y, output, 1 bit: stretched output level, intended for a level-sampling debounce receiver.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port pending, output, 2 bits: number of queued, not-yet-started requests.
REQ-010 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a request is dropped.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, HIGH and GAP, plus an 8-bit down-counter and a 2-bit pending counter.
REQ-012 The output y SHALL equal (state==HIGH), and busy SHALL equal (state!=IDLE), with no combinational path from trig to either.
REQ-013 IDLE, trig=1 at edge t: the FSM SHALL enter HIGH at edge t and load the counter with HIGH_CYCLES-1.
REQ-014 HIGH: the counter SHALL decrement each edge; at the edge where it reads 0, the FSM SHALL enter GAP and load GAP_CYCLES-1, so y is high for exactly HIGH_CYCLES periods.
REQ-015 GAP: the counter SHALL decrement each edge; at the edge where it reads 0, the FSM SHALL enter HIGH (reload HIGH_CYCLES-1, pending decremented) if pending>0, else IDLE.
REQ-016 trig=1 at an edge where the state is HIGH or GAP SHALL increment pending, saturating at QDEPTH.
REQ-017 trig=1 while pending==QDEPTH and a decrement is not occurring at the same edge SHALL drop the request and assert overflow for exactly the following cycle; pending remains QDEPTH.
REQ-018 trig=1 at the final GAP edge with pending>0 (simultaneous enqueue and dequeue) SHALL leave pending unchanged, with no overflow.
REQ-019 trig=1 in IDLE SHALL start a pulse directly and SHALL NOT change pending.
REQ-020 Consecutive rising edges of y SHALL be separated by at least HIGH_CYCLES+GAP_CYCLES periods.
REQ-021 A falling edge of y SHALL be followed by at least GAP_CYCLES low periods.
REQ-022 Illegal parameter values SHALL produce undefined behaviour, and no checking is required in RTL.

Reset
REQ-023 While reset=1, the block SHALL hold state=IDLE, counter=0, pending=0, y=0, busy=0 and overflow=0, taking effect immediately without a clock.
REQ-024 Reset asserted mid-HIGH or mid-GAP SHALL abort the pulse and discard all queued requests.
REQ-025 The first rising edge after reset release with trig=1 SHALL start a fresh pulse per REQ-013.

Verification (defaults H=4, G=2, Q=3; edge numbers are rising clk edges)
REQ-026 Single trig at edge 10: y=1 from edge 10 to edge 14; busy=1 from edge 10 to edge 16; IDLE at 16; pending stays 0.
REQ-027 Trig at edges 10 and 12: pending=1 from edge 12 to 16; the second y pulse spans edges 16 to 20; IDLE at 22.
REQ-028 Trig at edges 10 through 14 (five requests): pending reads 1,2,3,3; overflow is high in the cycle after edge 14; y rises at edges 10, 16, 22 and 28; IDLE at 34.
REQ-029 pending=1 with trig at the final GAP edge: pending stays 1, no overflow, and the next pulse starts at that edge.
REQ-030 Reset asserted mid-HIGH with pending=2: y, busy and pending go to 0 immediately; trig at the first edge after release starts one 4-cycle pulse only.
REQ-031 trig held at 1 for 20 consecutive edges from IDLE: pending saturates at 3, overflow pulses on every subsequent edge while saturated and not dequeuing, and exactly 4 pulses are emitted after release.
